// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - read-only instruction cache controller driving tag/line storage and word refills
// Optional ICACHE_FLUSH_EN adds flush_i and a valid-clear sweep over every (set, way).
module icache_ctrl #(
  parameter int WAY_COUNT      = 2,
  parameter int SET_COUNT      = 64,
  parameter int WAY_WORD_COUNT = 4,
  localparam int SI    = $clog2(SET_COUNT),
  localparam int WB    = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1,
  localparam int WI    = $clog2(WAY_WORD_COUNT),
  localparam int TAG_W = 32 - 2 - WI - SI
) (
  input  logic                        clk,
  input  logic                        reset,
`ifdef ICACHE_FLUSH_EN
  input  logic                        flush_i,
`endif
  input  logic                        core_req_i,
  input  logic [31:0]                 core_addr_i,
  output logic                        core_gnt_o,
  output logic                        core_rvalid_o,
  output logic [31:0]                 core_rdata_o,
  output logic                        mem_req_o,
  output logic [31:0]                 mem_addr_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [31:0]                 mem_rdata_i,
  output logic [SI-1:0]               cm_set_o,
  output logic [WB-1:0]               cm_way_o,
  output logic                        cm_enable_o,
  output logic                        cm_write_enable_o,
  output logic                        cm_val_write_enable_o,
  output logic                        cm_line_valid_o,
  output logic [TAG_W-1:0]            cm_line_tag_o,
  output logic [WAY_WORD_COUNT*32-1:0] cm_line_o,
  output logic [WAY_WORD_COUNT-1:0]   cm_line_ww_enable_o,
  input  logic [WAY_COUNT-1:0]        cm_line_valid_i,
  input  logic [TAG_W*WAY_COUNT-1:0]  cm_line_tag_i,
  input  logic [WAY_WORD_COUNT*32-1:0] cm_line_i
);

  typedef enum logic [2:0] {
    IDLE, CMP, DATA, REFILL, WRITE, RESP
`ifdef ICACHE_FLUSH_EN
    , FLUSH
`endif
  } state_t;

  state_t                      state, next_state;
  logic [TAG_W-1:0]            tag_q;
  logic [SI-1:0]               set_q;
  logic [WI-1:0]               word_q;
  logic [WB-1:0]               victim, rr_ptr, hit_way, inv_way;
  logic [WI-1:0]               cnt;
  logic                        pending, hit, inv_found, flush_go;
  logic [WAY_WORD_COUNT*32-1:0] line_buf;
  logic                        addr_unused;

  assign addr_unused = ^core_addr_i[1:0];

`ifdef ICACHE_FLUSH_EN
  logic              flush_pend;
  logic [SI+WB-1:0]  flush_cnt;
  assign flush_go = flush_i || flush_pend;

  // A flush seen mid-transaction is remembered and taken at the next IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_pend <= 1'b0;
      flush_cnt  <= '0;
    end else begin
      if (state == IDLE)  flush_pend <= 1'b0;
      else if (flush_i)   flush_pend <= 1'b1;
      if (state == FLUSH) flush_cnt <= flush_cnt + (SI+WB)'(1);
    end
  end
`else
  assign flush_go = 1'b0;
`endif

  assign core_gnt_o = (state == IDLE) && core_req_i && !reset && !flush_go;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (cm_line_valid_i[w] && (cm_line_tag_i[w*TAG_W +: TAG_W] == tag_q)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!cm_line_valid_i[w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WB'(w);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tag_q    <= '0;
      set_q    <= '0;
      word_q   <= '0;
      victim   <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      pending  <= 1'b0;
      line_buf <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (core_gnt_o) begin
          tag_q  <= core_addr_i[31 -: TAG_W];
          set_q  <= core_addr_i[2+WI +: SI];
          word_q <= core_addr_i[2 +: WI];
        end
        CMP: if (!hit) begin
          cnt     <= '0;
          pending <= 1'b0;
          if (inv_found) begin
            victim <= inv_way;
          end else begin
            victim <= rr_ptr;
            rr_ptr <= rr_ptr + WB'(1);
          end
        end
        REFILL: begin
          if (mem_req_o && mem_gnt_i) begin
            pending <= 1'b1;
          end else if (pending && mem_rvalid_i) begin
            line_buf[{cnt, 5'b0} +: 32] <= mem_rdata_i;
            cnt     <= cnt + WI'(1);
            pending <= 1'b0;
          end
        end
`ifdef ICACHE_FLUSH_EN
        FLUSH: if (flush_cnt == '1) rr_ptr <= '0;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state            = state;
    core_rvalid_o         = 1'b0;
    core_rdata_o          = '0;
    mem_req_o             = 1'b0;
    mem_addr_o            = '0;
    cm_set_o              = '0;
    cm_way_o              = '0;
    cm_enable_o           = 1'b0;
    cm_write_enable_o     = 1'b0;
    cm_val_write_enable_o = 1'b0;
    cm_line_valid_o       = 1'b0;
    cm_line_tag_o         = '0;
    cm_line_o             = '0;
    cm_line_ww_enable_o   = '0;
    case (state)
      IDLE: begin
`ifdef ICACHE_FLUSH_EN
        if (flush_go) next_state = FLUSH;
`endif
        if (core_gnt_o) begin
          next_state  = CMP;
          cm_set_o    = core_addr_i[2+WI +: SI];
          cm_enable_o = 1'b1;
        end
      end
      CMP: begin
        cm_set_o = set_q;
        if (hit) begin
          cm_way_o    = hit_way;
          cm_enable_o = 1'b1;
          next_state  = DATA;
        end else begin
          next_state = REFILL;
        end
      end
      DATA: begin
        core_rvalid_o = 1'b1;
        core_rdata_o  = cm_line_i[{word_q, 5'b0} +: 32];
        next_state    = IDLE;
      end
      REFILL: begin
        mem_req_o  = !pending;
        mem_addr_o = {tag_q, set_q, cnt, 2'b00};
        if (pending && mem_rvalid_i && (cnt == WI'(WAY_WORD_COUNT-1))) next_state = WRITE;
      end
      WRITE: begin
        cm_set_o            = set_q;
        cm_way_o            = victim;
        cm_enable_o         = 1'b1;
        cm_write_enable_o   = 1'b1;
        cm_line_valid_o     = 1'b1;
        cm_line_tag_o       = tag_q;
        cm_line_o           = line_buf;
        cm_line_ww_enable_o = '1;
        next_state          = RESP;
      end
      RESP: begin
        core_rvalid_o = 1'b1;
        core_rdata_o  = line_buf[{word_q, 5'b0} +: 32];
        next_state    = IDLE;
      end
`ifdef ICACHE_FLUSH_EN
      FLUSH: begin
        cm_set_o              = flush_cnt[WB +: SI];
        cm_way_o              = flush_cnt[WB-1:0];
        cm_enable_o           = 1'b1;
        cm_val_write_enable_o = 1'b1;
        if (flush_cnt == '1) next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Read-only cache controller. Sits between the core instruction port and backing memory.
- Drives the cache storage wrapper (set/way/enable/write-enable/line interface): tag lookup, hit data read, miss refill, victim choice.
- It is the initiator of the storage interface; the storage wrapper is the responder.

Parameters:
WAY_COUNT, 2, ways per set (power of 2)
SET_COUNT, 64, sets (power of 2)
WAY_WORD_COUNT, 4, 32-bit words per line (power of 2)
Derived field widths: word index = bits [2 +: log2(WAY_WORD_COUNT)], set index next, TAG_W = remaining upper bits to 31.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
core_req_i  in  1  core fetch request
core_addr_i  in  32  fetch byte address, word-aligned
core_gnt_o  out  1  request accepted
core_rvalid_o  out  1  read data valid, 1-cycle pulse
core_rdata_o  out  32  read data
mem_req_o  out  1  backing-memory word request
mem_addr_o  out  32  backing-memory word address
mem_gnt_i  in  1  backing-memory grant
mem_rvalid_i  in  1  backing-memory data valid
mem_rdata_i  in  32  backing-memory data
cm_set_o  out  log2(SET_COUNT)  storage set index
cm_way_o  out  log2(WAY_COUNT)  storage way index
cm_enable_o  out  1  storage access enable
cm_write_enable_o  out  1  line + tag + valid write
cm_val_write_enable_o  out  1  valid-only write
cm_line_valid_o  out  1  valid bit to write
cm_line_tag_o  out  TAG_W  tag to write
cm_line_o  out  WAY_WORD_COUNT*32  line to write
cm_line_ww_enable_o  out  WAY_WORD_COUNT  per-word write enable
cm_line_valid_i  in  WAY_COUNT  valid bits of cm_set_o (combinational)
cm_line_tag_i  in  TAG_W*WAY_COUNT  tags, 1 cycle after enable
cm_line_i  in  WAY_WORD_COUNT*32  line of (set, way), 1 cycle after enable

Behaviour:
- States: IDLE, CMP, DATA, REFILL, WRITE, RESP (plus FLUSH with option).
- Reset: all outputs 0, including core_gnt_o. State IDLE. Round-robin pointer, refill counter, line buffer and address register cleared.
- Reset mid-refill aborts the refill. No storage write occurs. Later mem_rvalid_i is ignored until a new refill issues a request.
- IDLE:
  - core_gnt_o = core_req_i (combinational, forced 0 while reset).
  - On grant: latch address; cm_set_o = set field of core_addr_i; cm_enable_o = 1; go to CMP.
- CMP:
  - hit = cm_line_valid_i[w] && tag match for way w. At most one way can hit.
  - Hit: cm_way_o = hit way, cm_enable_o = 1, go to DATA.
  - Miss: go to REFILL.
- DATA: core_rvalid_o = 1, core_rdata_o = cm_line_i word[latched word idx]; go to IDLE. Hit latency: rvalid 2 cycles after gnt.
- Victim selection, fixed in CMP on miss: lowest-index invalid way; otherwise rr_ptr. rr_ptr increments (wrapping) only when it is used as the victim.
- REFILL:
  - Fetches WAY_WORD_COUNT words, word 0 first.
  - mem_addr_o = {tag, set, cnt, 2'b00}.
  - One outstanding request: mem_req_o held high until mem_gnt_i, then low until mem_rvalid_i.
  - On mem_rvalid_i: store mem_rdata_i into buffer[cnt], increment cnt.
  - mem_rvalid_i with no request outstanding is ignored.
  - After the last word, go to WRITE.
- WRITE:
  - cm_enable_o = cm_write_enable_o = 1, cm_line_valid_o = 1, cm_line_tag_o = latched tag.
  - cm_way_o = victim, cm_line_ww_enable_o = all ones, cm_line_o = buffer.
  - Go to RESP.
- RESP: core_rvalid_o = 1, core_rdata_o = buffer[word idx]; go to IDLE.
- Only one core transaction in flight. core_gnt_o is 0 outside IDLE.
- cm_* outputs are 0 in states that do not drive them.

Optional Feature:
- Macro: ICACHE_FLUSH_EN.
- With the macro: adds input flush_i (1 bit).
  - flush_i sampled high in IDLE takes priority over core_req_i and enters FLUSH.
  - FLUSH writes cm_val_write_enable_o = 1, cm_enable_o = 1, cm_line_valid_o = 0 for every (set, way), one per cycle, set-major order: SET_COUNT*WAY_COUNT cycles.
  - flush_i received outside IDLE is held pending and serviced at the next IDLE.
  - rr_ptr resets to 0 at the end of FLUSH.
- Without the macro: no flush_i port, no FLUSH state; cm_val_write_enable_o tied 0.

Test Plan:
- Cold miss: memory returns 0x1000_0000+addr. Fetch 0x0000_0108 -> 4 mem requests at 0x100, 0x104, 0x108, 0x10C; WRITE set 0x10 way 0 with tag 0; core_rdata_o = 0x1000_0108.
- Hit after fill: fetch 0x0000_010C -> no mem_req_o; core_rvalid_o 2 cycles after gnt; data 0x1000_010C.
- Conflict: fill 0x100, then 0x900 (same set, way 1), then 0x1100 -> victim way 0 (rr_ptr = 0); next conflict miss uses way 1.
- Memory stall: mem_gnt_i delayed 3 cycles and rvalid delayed 2 per word -> mem_req_o stays high until gnt; buffer order correct; one request at a time.
- Reset asserted mid-refill after word 1 -> all outputs 0 immediately; no cm_write_enable_o pulse; refetch of the same address misses and refills fully.
- ICACHE_FLUSH_EN: fill 2 lines, pulse flush_i -> 128 valid-clear writes; a later fetch to either line misses.
